logic_sweep_unit: RTL

- Parametrised, registered successor to the two-input gate functions (~a & b and XNOR).
- Evaluates a selectable bitwise function on WIDTH-bit operands.
- Direct mode: operands arrive over a valid/ready handshake.
- Sweep mode: the block generates every operand pair internally and emits the full truth table in order.
- Used as a self-checking stimulus/response source for gate-level test benches in the guide exercises.

---
 rtl/logic_sweep_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/logic_sweep_unit.sv
// logic_sweep_unit
// Registered, parametrised bitwise-function unit with two operand sources:
//   direct mode - operands arrive over a valid/ready handshake;
//   sweep mode  - an internal 2*WIDTH-bit counter walks every (a,b) pair,
//                 a-major / b-minor, emitting the full truth table once.
// Functions (op): 00 ANDN (~a & b), 01 XNOR, 10 AND, 11 XOR.
//
// Ports
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   op                   function select (latched at sweep start)
//   start                one-cycle sweep request (wins over in_valid in IDLE)
//   in_valid/in_ready    direct-mode handshake (in_ready is combinational)
//   in_a, in_b           direct-mode operands
//   out_valid/out_ready  single-stage result register handshake
//   out_a, out_b, out_s  registered entry: operands and result
//   busy                 high in SWEEP and DONE
//   done                 one-cycle pulse when the sweep completes
//   ones_count           (LOGIC_SWEEP_STATS_EN only) sum of popcount(out_s)
//                        over the entries of the current/last sweep
//
// Optional feature macro: LOGIC_SWEEP_STATS_EN
module logic_sweep_unit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       op,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_s,
    output logic             busy,
`ifdef LOGIC_SWEEP_STATS_EN
    output logic             done,
    output logic [2*WIDTH+3:0] ones_count
`else
    output logic             done
`endif
);

    localparam int unsigned CNT_W  = 2 * WIDTH;
    localparam int unsigned STAT_W = 2 * WIDTH + 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Bitwise function table shared by both operand sources.
    function automatic logic [WIDTH-1:0] eval_fn(
        input logic [1:0]       f,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (f)
            2'b00:   r = ~a & b;
            2'b01:   r = ~(a ^ b);
            2'b10:   r = a & b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_a_q, out_b_q, out_s_q;
    logic               busy_q, done_q;

    logic               load_c;
    logic               in_ready_c;
    logic               ent_vld_c;
    logic [WIDTH-1:0]   ent_a_c, ent_b_c, ent_s_c;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the sweep ends on the cycle that loads the all-ones entry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SWEEP;
            ST_SWEEP: if (load_c && (cnt_q == '1)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output/entry-select logic: picks the operand source and handshake.
    always_comb begin
        load_c     = !out_valid_q || out_ready;
        in_ready_c = 1'b0;
        ent_vld_c  = 1'b0;
        ent_a_c    = in_a;
        ent_b_c    = in_b;
        ent_s_c    = eval_fn(op, in_a, in_b);
        case (state_q)
            ST_IDLE: begin
                // start has priority: no direct operand is taken that cycle
                in_ready_c = rst_n && !start && load_c;
                ent_vld_c  = in_valid && in_ready_c;
            end
            ST_SWEEP: begin
                ent_vld_c = load_c;
                ent_a_c   = cnt_q[CNT_W-1:WIDTH];
                ent_b_c   = cnt_q[WIDTH-1:0];
                ent_s_c   = eval_fn(op_q, cnt_q[CNT_W-1:WIDTH], cnt_q[WIDTH-1:0]);
            end
            default: begin
                in_ready_c = 1'b0;
                ent_vld_c  = 1'b0;
            end
        endcase
    end

    // Result register, sweep counter, latched function and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_s_q     <= '0;
            cnt_q       <= '0;
            op_q        <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (load_c) begin
                out_valid_q <= ent_vld_c;
                if (ent_vld_c) begin
                    out_a_q <= ent_a_c;
                    out_b_q <= ent_b_c;
                    out_s_q <= ent_s_c;
                end
            end
            if ((state_q == ST_IDLE) && start) begin
                op_q  <= op;
                cnt_q <= '0;
            end else if ((state_q == ST_SWEEP) && load_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            busy_q <= (state_d != ST_IDLE);
            done_q <= (state_d == ST_DONE);
        end
    end

`ifdef LOGIC_SWEEP_STATS_EN
    function automatic logic [STAT_W-1:0] popcount(input logic [WIDTH-1:0] x);
        logic [STAT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            n = n + STAT_W'(x[i]);
        end
        return n;
    endfunction

    logic [STAT_W-1:0] ones_q;

    // Ones accumulator over sweep entries only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ones_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            ones_q <= '0;
        end else if ((state_q == ST_SWEEP) && load_c) begin
            ones_q <= ones_q + popcount(ent_s_c);
        end
    end

    assign ones_count = ones_q;
`endif

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_s     = out_s_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
